// File: rtl/pipelined_carry_adder_pkg.sv
// Shared definitions for pipelined_carry_adder: stage-count helper, segment type,
// and a width-check macro that stops elaboration when WIDTH is not a multiple of SEG_W.
`ifndef PIPE_CARRY_ADDER_PKG_SV
`define PIPE_CARRY_ADDER_PKG_SV

`define PIPE_CARRY_ADDER_WIDTH_CHECK(W, S) \
    if (((W) % (S)) != 0) begin : g_width_check \
        $error("pipelined_carry_adder: WIDTH must be a multiple of SEG_W"); \
    end

package pipe_carry_adder_pkg;

    localparam int unsigned SEG_W_DEFAULT = 32'd4;

    typedef logic [SEG_W_DEFAULT-1:0] seg_t;

    function automatic int unsigned stages(input int unsigned width, input int unsigned seg_w);
        return width / seg_w;
    endfunction

endpackage

`endif

// File: rtl/pipelined_carry_adder_rca_segment.sv
// rca_segment: combinational SEG_W-bit ripple-carry adder used once per pipeline stage.
module rca_segment
    import pipe_carry_adder_pkg::*;
#(
    parameter int unsigned SEG_W = SEG_W_DEFAULT
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co
);

    logic [SEG_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[SEG_W];

endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract split into SEG_W-bit ripple stages with
// valid/ready handshakes. Define PIPE_CARRY_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_carry_adder
    import pipe_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd16,
    parameter int unsigned SEG_W = 32'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = int'(stages(WIDTH, SEG_W));
    localparam int LAST   = STAGES - 1;

    `PIPE_CARRY_ADDER_WIDTH_CHECK(WIDTH, SEG_W)

    logic              en;
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nxt;
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];

`ifdef PIPE_CARRY_ADDER_OVF_EN
    logic ovf_r;
`endif

    // A full output slot that is not being drained freezes the whole pipe.
    assign en       = !v_r[LAST] | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG_W-1:0] seg_sum;
        logic             seg_co;

        if (k == 0) begin : g_first
            assign a_in[k] = a;
            assign b_in[k] = sub ? ~b : b;
            assign c_in[k] = sub ? ~cin : cin;
            assign s_in[k] = '0;
            assign v_in[k] = in_valid;
        end else begin : g_next
            assign a_in[k] = a_r[k-1];
            assign b_in[k] = b_r[k-1];
            assign c_in[k] = c_r[k-1];
            assign s_in[k] = s_r[k-1];
            assign v_in[k] = v_r[k-1];
        end

        rca_segment #(.SEG_W(SEG_W)) u_seg (
            .a  (a_in[k][k*SEG_W +: SEG_W]),
            .b  (b_in[k][k*SEG_W +: SEG_W]),
            .ci (c_in[k]),
            .s  (seg_sum),
            .co (seg_co)
        );

        // Segments at and above k are still zero, so OR drops the new segment in place.
        assign s_nxt[k] = s_in[k] | (WIDTH'(seg_sum) << (k * SEG_W));
        assign c_nxt[k] = seg_co;
    end

    // Stage registers: valid chain, carries, forwarded operands and skewed partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= '0;
            c_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
`ifdef PIPE_CARRY_ADDER_OVF_EN
            ovf_r <= 1'b0;
`endif
        end else if (en) begin
            v_r <= v_in;
            c_r <= c_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= a_in[k];
                b_r[k] <= b_in[k];
                s_r[k] <= s_nxt[k];
            end
`ifdef PIPE_CARRY_ADDER_OVF_EN
            ovf_r <= (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &
                     (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
`endif
        end
    end

    assign out_valid = v_r[LAST];
    assign sum       = s_r[LAST];
    assign cout      = c_r[LAST];
`ifdef PIPE_CARRY_ADDER_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=16, SEG_W=4): directed cases,
// stall/reset scenarios and random traffic against an arithmetic reference queue.
module tb_pipelined_carry_adder;

    localparam int STAGES = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    exp_t q[$];

    pipelined_carry_adder #(.WIDTH(16), .SEG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPE_CARRY_ADDER_OVF_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

`ifndef PIPE_CARRY_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
        exp_t        e;
        int unsigned ua;
        int unsigned ub;
        int          sa;
        int          sb;
        int          r;
        ua = int'(ta);
        ub = int'(tb_);
        sa = int'($signed(ta));
        sb = int'($signed(tb_));
        if (!ts) begin
            e.s = 16'((ua + ub + tc) & 32'hFFFF);
            e.c = (ua + ub + tc) > 32'd65535;
            r   = sa + sb + int'(tc);
        end else begin
            e.s = 16'((ua - ub - tc) & 32'hFFFF);
            e.c = ua >= (ub + tc);
            r   = sa - sb - int'(tc);
        end
`ifdef PIPE_CARRY_ADDER_OVF_EN
        e.v = (r > 32767) || (r < -32768);
`else
        e.v = 1'b0;
`endif
        return e;
    endfunction

    // Compare process: track accepts, check every output transfer and hold stability.
    logic        held_valid = 1'b0;
    logic [17:0] held_val;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid && out_valid)
                check("hold_stable", {14'd0, sum, cout, ovf}, {14'd0, held_val});
            held_valid = out_valid && !out_ready;
            held_val   = {sum, cout, ovf};
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                acc_cnt++;
                check("inflight_limit", 32'(q.size() <= STAGES + 1), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("model_sum", {16'd0, sum}, {16'd0, e.s});
                    check("model_cout", {31'd0, cout}, {31'd0, e.c});
`ifdef PIPE_CARRY_ADDER_OVF_EN
                    check("model_ovf", {31'd0, ovf}, {31'd0, e.v});
`endif
                end
            end
        end
    end

    // Present a beat (caller at posedge+2) and hold until accepted.
    task automatic send_beat(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
        int   n;
        logic acc;
        n = 0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #2;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Single beat with out_ready=1; literal expectations and latency check.
    task automatic run_one(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tc, input logic ts, input logic [15:0] es, input logic ec,
                           input logic ev);
        int lat;
        lat = 0;
        send_beat(ta, tb_, tc, ts);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({name, "_latency"}, 32'(lat), 32'(STAGES));
        check({name, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef PIPE_CARRY_ADDER_OVF_EN
        check({name, "_ovf"}, {31'd0, ovf}, {31'd0, ev});
`else
        if (ev) check({name, "_ovf_unexpected"}, {31'd0, ovf}, 32'd0);
`endif
        @(posedge clk); #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int   seen;
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_sum", {16'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);

        // Pin the reference model itself with hand-computed values.
        check("pin_add", 32'(model(16'h0001, 16'h0001, 1'b0, 1'b0)), 32'({16'h0002, 1'b0, 1'b0}));
        check("pin_carry", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'({16'h0000, 1'b1, 1'b0}));
        check("pin_sub_neg", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'({16'hFFFE, 1'b0, 1'b0}));

        run_one("add_small", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_one("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_one("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_one("sub_borrow", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Stall: six back-to-back beats against a blocked consumer.
        out_ready = 1'b0;
        acc_cnt   = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_beat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall_accepts", 32'(acc_cnt), 32'd4);
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight, one already at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_beat(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk); #2;
        check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_sum", {16'd0, sum}, 32'd0);
        @(posedge clk); #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_after_reset", 32'(seen), 32'd0);
        @(posedge clk); #2;

        // Random traffic with random backpressure.
        acc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #2;
            out_ready = ($urandom_range(0, 99) < 70);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 99) < 75);
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
                if ($urandom_range(0, 9) == 0) a = 16'hFFFF;
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
